// File: rtl/cp0_timer_int_pkg.sv
// cp0_timer_int_pkg -- shared CP0 register numbers and write-port record.
// Holds the CP0 register address constants used by the CP0 blocks
// (Status/Cause/EPC alongside the timer's Count/Compare) and the packed
// write request struct consumed by cp0_timer_int.
package cp0_timer_int_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam int         EXT_INT_W    = 6;
  localparam logic       WRITE_ENABLE = 1'b1;
  localparam logic       READ_ENABLE  = 1'b1;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } cp0_wr_t;

endpackage

// File: rtl/cp0_timer_int_sync.sv
// int_sync -- WIDTH-bit two-flop synchronizer for asynchronous level inputs.
// Ports:
//   clk  : sampling clock
//   rst  : asynchronous active-high reset, clears both stages
//   d_i  : asynchronous input levels
//   q_o  : synchronized levels, two rising edges of latency
module int_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cp0_timer_int.sv
// cp0_timer_int -- CP0 Count/Compare timer plus hardware interrupt sync.
// Count advances once every two clocks; a Compare write arms the timer and
// clears any pending timer interrupt; a match of Count and Compare while
// armed sets a sticky pending flag that is merged onto HW5.
// Ports:
//   cpu_clk_50M : system clock, rising edge
//   cpu_rst     : asynchronous active-high reset
//   ext_int_i   : asynchronous HW0..HW5 interrupt levels
//   we/waddr/wdata : CP0 write port (Count and Compare decoded here)
//   re/raddr    : CP0 read port
//   data_o      : Count/Compare read data, zero otherwise
//   int_o       : pending hardware interrupts for Cause IP[7:2]
//   timer_int_o : timer interrupt pending
module cp0_timer_int
  import cp0_timer_int_pkg::*;
(
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst,
  input  logic [EXT_INT_W-1:0] ext_int_i,
  input  logic                 we,
  input  logic [4:0]           waddr,
  input  logic [31:0]          wdata,
  input  logic                 re,
  input  logic [4:0]           raddr,
  output logic [31:0]          data_o,
  output logic [EXT_INT_W-1:0] int_o,
  output logic                 timer_int_o
);

  cp0_wr_t wr;
  logic    wr_count, wr_compare;

  logic [31:0] count_d, count_q;
  logic [31:0] compare_d, compare_q;
  logic        phase_d, phase_q;
  logic        armed_d, armed_q;
  logic        tpend_d, tpend_q;

  logic [EXT_INT_W-1:0] ext_sync;

  always_comb begin
    wr.we   = we;
    wr.addr = waddr;
    wr.data = wdata;
  end

  assign wr_count   = (wr.we == WRITE_ENABLE) && (wr.addr == CP0_COUNT);
  assign wr_compare = (wr.we == WRITE_ENABLE) && (wr.addr == CP0_COMPARE);

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    phase_d   = ~phase_q;
    armed_d   = armed_q;
    tpend_d   = tpend_q;

    // Natural 32-bit wrap on overflow.
    if (phase_q) count_d = count_q + 32'd1;

    // Software Count write beats the increment and restarts the divider.
    if (wr_count) begin
      count_d = wr.data;
      phase_d = 1'b0;
    end

    // Compare write acknowledges the interrupt and wins over a match
    // seen in the same cycle. Match uses pre-edge count/compare.
    if (wr_compare) begin
      compare_d = wr.data;
      armed_d   = 1'b1;
      tpend_d   = 1'b0;
    end else if (armed_q && (count_q == compare_q)) begin
      tpend_d   = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      count_q   <= '0;
      compare_q <= '0;
      phase_q   <= 1'b0;
      armed_q   <= 1'b0;
      tpend_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      phase_q   <= phase_d;
      armed_q   <= armed_d;
      tpend_q   <= tpend_d;
    end
  end

  int_sync #(.WIDTH(EXT_INT_W)) u_int_sync (
    .clk (cpu_clk_50M),
    .rst (cpu_rst),
    .d_i (ext_int_i),
    .q_o (ext_sync)
  );

  // Only registered signals reach int_o: no path from ext_int_i.
  assign int_o       = {ext_sync[5] | tpend_q, ext_sync[4:0]};
  assign timer_int_o = tpend_q;

  // Reads return registered (pre-edge) state, never the write data.
  always_comb begin
    data_o = '0;
    if (!cpu_rst && (re == READ_ENABLE)) begin
      if (raddr == CP0_COUNT)        data_o = count_q;
      else if (raddr == CP0_COMPARE) data_o = compare_q;
    end
  end

endmodule

// File: doc/cp0_timer_int.md
CP0_TIMER_INT -- requirements
Module: cp0_timer_int

Interface
REQ-001 SHALL have port cpu_clk_50M  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port cpu_rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port ext_int_i  input  6  asynchronous hardware interrupt lines HW0..HW5, active-high level.
REQ-004 SHALL have port we  input  1  CP0 write enable (WRITE_ENABLE = 1).
REQ-005 SHALL have port waddr  input  5  CP0 write register number.
REQ-006 SHALL have port wdata  input  32  CP0 write data.
REQ-007 SHALL have port re  input  1  CP0 read enable (READ_ENABLE = 1).
REQ-008 SHALL have port raddr  input  5  CP0 read register number.
REQ-009 SHALL have port data_o  output  32  read data for Count/Compare, else zero.
REQ-010 SHALL have port int_o  output  6  pending hardware interrupts, drives the Cause IP[7:2] input (cause[15:10]) of the CP0 register file.
REQ-011 SHALL have port timer_int_o  output  1  timer interrupt pending flag.

Function
REQ-012 SHALL decode CP0_COUNT = 5'd9 and CP0_COMPARE = 5'd11; all other addresses are ignored for writes.
REQ-013 SHALL hold a 1-bit phase toggle; count increments by 1 on every edge where phase = 1, so count advances once per 2 cycles.
REQ-014 SHALL wrap count from 32'hFFFFFFFF to 32'h00000000 with no other side effect.
REQ-015 SHALL, on we = 1 and waddr = CP0_COUNT, load count <= wdata and phase <= 0; this write overrides the increment in the same cycle.
REQ-016 SHALL, on we = 1 and waddr = CP0_COMPARE, load compare <= wdata, set armed <= 1, and clear timer pending in that same edge.
REQ-017 SHALL set timer pending at an edge where armed = 1, count == compare (pre-edge values), and no Compare write occurs that cycle; a Compare write wins over a simultaneous match.
REQ-018 SHALL keep timer pending set (sticky) until a Compare write or reset; count continuing past compare does not clear it.
REQ-019 SHALL drive timer_int_o = timer pending register directly.
REQ-020 SHALL pass each ext_int_i bit through a 2-flop synchronizer; a level asserted before edge N is visible on int_o after edge N+1.
REQ-021 SHALL drive int_o[4:0] = synchronized ext_int[4:0] and int_o[5] = synchronized ext_int[5] OR timer pending.
REQ-022 SHALL not latch external interrupts: int_o[4:0] deasserts 2 edges after the source deasserts.
REQ-023 SHALL drive data_o combinationally: zero when cpu_rst = 1 or re = 0; count when raddr = CP0_COUNT; compare when raddr = CP0_COMPARE; zero otherwise.
REQ-024 SHALL return pre-edge values on a read concurrent with a write to the same register (no write-through bypass).

Reset
REQ-025 SHALL, while cpu_rst = 1, force count = 0, compare = 0, phase = 0, armed = 0, timer pending = 0, both synchronizer stages = 0.
REQ-026 SHALL therefore drive int_o = 6'b0, timer_int_o = 0, data_o = 0 during reset, asynchronously on assertion.
REQ-027 SHALL abandon any in-progress count or pending interrupt on mid-operation reset; no match fires after release until Compare is written (armed = 0).

Structure
REQ-028 SHALL place CP0_COUNT and CP0_COMPARE address constants in the shared defines.v alongside CP0_STATUS/CP0_CAUSE/CP0_EPC.
REQ-029 SHALL instantiate one sub-module int_sync (parameterised width, 2-flop synchronizer, async active-high reset) for ext_int_i.
REQ-030 SHALL be 120-400 lines of RTL with no memories and no combinational path from ext_int_i to int_o.

Verification
REQ-031 Reset release, no writes, 200 cycles -> count = 100, timer_int_o = 0 (armed = 0 despite compare = 0 match at start).
REQ-032 Write Count = 32'hFFFFFFFE, then wait 4 cycles -> count reads 0x00000000 (wrap), no spurious interrupt.
REQ-033 Write Compare = 10, Count = 0 -> timer_int_o rises at the edge after count = 10; int_o[5] = 1; write Compare = 50 -> both clear next edge.
REQ-034 Compare write in the same cycle that count == compare -> timer_int_o stays 0 that edge.
REQ-035 Pulse ext_int_i[2] high for 3 cycles -> int_o[2] high for exactly 3 cycles, starting 2 edges later.
REQ-036 Assert cpu_rst mid-count with timer_int_o = 1 -> int_o, timer_int_o, data_o read 0 immediately (before next clock edge).
